// File: rtl/sample_reader.sv
// Drains the sampler's playback port: each sample is forwarded as a one-byte
// transmit request, and the sampler is paced with single-cycle next pulses.
module sample_reader #(
  parameter int DATA_SIZE    = 8,
  parameter int SAMPLE_COUNT = 1024,
  parameter int CNT_SIZE     = 11,
  parameter int TIMEOUT      = 4096
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_next,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_busy,
  output logic [CNT_SIZE-1:0]  o_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_SIZE-1:0] CNT_FULL = CNT_SIZE'(SAMPLE_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VALID,
    SEND,
    WAIT_ACK,
    WAIT_TX,
    NEXT,
    DONE
  } state_t;

  state_t           state;
  logic             last_valid;
  logic             val_rise;
  logic [TMR_W-1:0] timer;

  // The sample count stops at a full capture instead of wrapping.
  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (v == CNT_FULL) ? v : v + 1'b1;
  endfunction

  assign val_rise = i_valid & ~last_valid;
  assign o_busy   = (state != IDLE);

  // Start is decoded combinationally so it can fire in the first SEND cycle;
  // dropping enable suppresses a start that has not yet been issued.
  assign o_tx_start = (state == SEND) && !i_tx_busy && i_enable;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      last_valid <= 1'b0;
      timer      <= '0;
      o_count    <= '0;
      o_tx_data  <= '0;
      o_next     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      last_valid <= i_valid;
      o_next     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      if (!i_enable) begin
        state   <= IDLE;
        timer   <= '0;
        o_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            timer   <= '0;
            o_count <= '0;
            state   <= WAIT_VALID;
          end
          WAIT_VALID: begin
            if (val_rise) begin
              o_tx_data <= i_data;
              o_count   <= sat_inc(o_count);
              timer     <= '0;
              state     <= SEND;
            end else if (timer == TMR_LAST) begin
              o_error <= 1'b1;
              timer   <= '0;
              o_count <= '0;
              state   <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SEND: begin
            if (!i_tx_busy) state <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (i_tx_busy) state <= WAIT_TX;
          end
          WAIT_TX: begin
            if (!i_tx_busy) begin
              if (o_count == CNT_FULL) begin
                o_done <= 1'b1;
                state  <= DONE;
              end else begin
                o_next <= 1'b1;
                state  <= NEXT;
              end
            end
          end
          NEXT: begin
            timer <= '0;
            state <= WAIT_VALID;
          end
          DONE: begin
            o_count <= '0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_reader.sv
// Scoreboard bench for sample_reader: sampler and transmitter models drive the
// DUT, expected bytes are queued as samples are presented and popped on each start.
module tb_sample_reader;
  localparam int DW = 8;
  localparam int SC = 4;
  localparam int CW = 3;
  localparam int TO = 16;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_tx_busy;
  logic          o_next, o_tx_start, o_busy, o_done, o_error;
  logic [DW-1:0] o_tx_data;
  logic [CW-1:0] o_count;

  logic busy_force = 1'b0;
  int   tx_len = 10;
  int   tx_left = 0;

  int vectors = 0;
  int miscompares = 0;
  int n_next = 0, n_done = 0, n_err = 0, n_start = 0;
  logic [DW-1:0] exp_q[$];
  logic prev_next = 1'b0, prev_start = 1'b0;

  sample_reader #(
    .DATA_SIZE(DW), .SAMPLE_COUNT(SC), .CNT_SIZE(CW), .TIMEOUT(TO)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_valid(i_valid), .i_data(i_data), .o_next(o_next),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
    .o_count(o_count), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clock = ~i_clock;

  // Transmitter model: busy for tx_len cycles after each accepted start.
  assign i_tx_busy = busy_force | (tx_left != 0);
  always @(posedge i_clock) begin
    if (o_tx_start && tx_left == 0) tx_left <= tx_len;
    else if (tx_left != 0)          tx_left <= tx_left - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each start and tallies pulse events.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge i_clock);
      if (o_tx_start) begin
        n_start++;
        chk("start_single_cycle", prev_start, 0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got start with 0x%0h, expected no start", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", o_tx_data, e);
        end
      end
      if (o_next) begin
        n_next++;
        chk("next_single_cycle", prev_next, 0);
      end
      if (o_done)  n_done++;
      if (o_error) n_err++;
      prev_next  = o_next;
      prev_start = o_tx_start;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  // sel: 0 = o_next, 1 = o_done, 2 = o_tx_start
  task automatic wait_for(input int sel, input string name);
    int k = 0;
    while (!((sel == 0 && o_next) || (sel == 1 && o_done) || (sel == 2 && o_tx_start))
           && k < 300) begin
      tick(1);
      k++;
    end
    if (k >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no event in %0d cycles, expected one", name, k);
    end
  endtask

  task automatic present(input logic [DW-1:0] d, input int hold);
    i_data  = d;
    i_valid = 1'b1;
    exp_q.push_back(d);
    tick(hold);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    i_enable   = 1'b0;
    busy_force = 1'b0;
    while (i_tx_busy && k < 100) begin
      tick(1);
      k++;
    end
    tick(2);
  endtask

  task automatic run_full(input logic [SC*DW-1:0] samples, input string tag);
    int nx0, dn0, er0, st0;
    nx0 = n_next; dn0 = n_done; er0 = n_err; st0 = n_start;
    i_enable = 1'b1;
    tick(1);
    for (int i = 0; i < SC; i++) begin
      if (i > 0) wait_for(0, {tag, "_next"});
      tick($urandom_range(1, 6));
      present(samples[i*DW +: DW], $urandom_range(1, 3));
    end
    wait_for(1, {tag, "_done"});
    chk({tag, "_count_at_done"}, o_count, SC);
    i_enable = 1'b0;
    tick(1);
    chk({tag, "_busy_after_done"}, o_busy, 0);
    tick(2);
    chk({tag, "_starts"}, n_start - st0, SC);
    chk({tag, "_nexts"}, n_next - nx0, SC - 1);
    chk({tag, "_dones"}, n_done - dn0, 1);
    chk({tag, "_errors"}, n_err - er0, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx0, dn0, st0;
    // Reset values
    tick(2);
    chk("rst_busy", o_busy, 0);
    chk("rst_count", o_count, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_next", o_next, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_tx_start", o_tx_start, 0);
    i_reset = 1'b1;
    tick(2);

    // Full capture with known samples
    tx_len = 10;
    run_full(32'h44332211, "full");

    // Randomized captures with varying transmitter lengths
    for (int r = 0; r < 3; r++) begin
      tx_len = $urandom_range(3, 12);
      run_full($urandom, "rnd");
    end
    tx_len = 10;

    // Single-cycle valid is still captured
    i_enable = 1'b1;
    tick(2);
    present(8'hA5, 1);
    chk("pulse_start", o_tx_start, 1);
    chk("pulse_data", o_tx_data, 8'hA5);
    chk("pulse_count", o_count, 1);
    tick(1);
    chk("pulse_start_ends", o_tx_start, 0);
    drain();

    // Transmitter busy at capture stalls the start
    st0 = n_start;
    i_enable   = 1'b1;
    busy_force = 1'b1;
    tick(2);
    present(8'h5A, 1);
    chk("stall_no_start", o_tx_start, 0);
    chk("stall_data", o_tx_data, 8'h5A);
    tick(17);
    chk("stall_still_waiting", o_tx_start, 0);
    busy_force = 1'b0;
    #1;
    chk("stall_start", o_tx_start, 1);
    tick(1);
    chk("stall_start_ends", o_tx_start, 0);
    tick(2);
    chk("stall_one_start", n_start - st0, 1);
    drain();

    // Timeout with no sample
    i_enable = 1'b1;
    tick(1);
    chk("to_busy", o_busy, 1);
    tick(TO - 1);
    chk("to_not_early", o_error, 0);
    tick(1);
    chk("to_error", o_error, 1);
    chk("to_idle", o_busy, 0);
    chk("to_count", o_count, 0);
    i_enable = 1'b0;
    tick(1);
    chk("to_error_single", o_error, 0);
    tick(2);

    // Enable dropped after two samples
    i_enable = 1'b1;
    tick(3);
    present(8'h81, 2);
    wait_for(0, "ed_next");
    tick(2);
    present(8'h82, 1);
    wait_for(2, "ed_start2");
    chk("ed_count2", o_count, 2);
    tick(2);
    nx0 = n_next;
    dn0 = n_done;
    i_enable = 1'b0;
    tick(1);
    chk("ed_idle", o_busy, 0);
    chk("ed_count_cleared", o_count, 0);
    tick(25);
    chk("ed_no_next", n_next - nx0, 0);
    chk("ed_no_done", n_done - dn0, 0);
    drain();

    // Asynchronous reset while waiting for the transmitter
    i_enable = 1'b1;
    tick(3);
    present(8'hC3, 1);
    tick(4);
    chk("ar_in_progress", o_busy, 1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("ar_busy", o_busy, 0);
    chk("ar_count", o_count, 0);
    chk("ar_tx_data", o_tx_data, 0);
    chk("ar_next", o_next, 0);
    chk("ar_done", o_done, 0);
    chk("ar_error", o_error, 0);
    chk("ar_tx_start", o_tx_start, 0);
    tick(1);
    i_reset = 1'b1;
    tick(2);
    present(8'h3C, 1);
    chk("ar_recapture_count", o_count, 1);
    chk("ar_recapture_data", o_tx_data, 8'h3C);
    wait_for(2, "ar_start");
    tick(2);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_error_total", n_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
